i2c_target: RTL and testbench

//   I2C target (responder) for the system_clk domain: oversamples SCL/SDA, detects START/STOP,

---
 rtl/i2c_target_pkg.sv | 23 ++
 rtl/i2c_line_filter.sv | 56 +++++
 rtl/i2c_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: one-hot FSM state encodings,
// ACK/NACK bus levels and the default target address.
package i2c_target_pkg;

  localparam logic [6:0] DEFAULT_ADDR  = 7'h50;
  localparam logic       ACK_BIT       = 1'b0;
  localparam logic       NACK_BIT      = 1'b1;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  typedef enum logic [9:0] {
    ST_IDLE      = 10'b00_0000_0001,
    ST_ADDR      = 10'b00_0000_0010,
    ST_ADDR_ACK  = 10'b00_0000_0100,
    ST_PTR       = 10'b00_0000_1000,
    ST_PTR_ACK   = 10'b00_0001_0000,
    ST_WDATA     = 10'b00_0010_0000,
    ST_WDATA_ACK = 10'b00_0100_0000,
    ST_RDATA     = 10'b00_1000_0000,
    ST_RACK      = 10'b01_0000_0000,
    ST_IGNORE    = 10'b10_0000_0000
  } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Debounces raw SCL/SDA and derives SCL edges plus START/STOP conditions
// from the filtered levels and their one-cycle-old copies.
module i2c_line_filter #(
  parameter int FILTER_LEN = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0]    sync_q;
  logic [1:0]    filt_q;
  logic [1:0]    prev_q;
  logic [CW-1:0] cnt_q [2];

  // A lane adopts a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      filt_q   <= 2'b11;
      prev_q   <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync_q <= {sda_i, scl_i};
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sda_o       = filt_q[1];
  assign scl_rise_o  =  filt_q[0] & ~prev_q[0];
  assign scl_fall_o  = ~filt_q[0] &  prev_q[0];
  assign start_det_o =  filt_q[0] &  prev_q[0] &  prev_q[1] & ~filt_q[1];
  assign stop_det_o  =  filt_q[0] &  prev_q[0] & ~prev_q[1] &  filt_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match with ACK, auto-incrementing 8-bit register pointer,
// and bridging of write/read bytes onto a strobed register port.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = DEFAULT_ADDR,
  parameter int         FILTER_LEN = 5
) (
  input  logic       system_clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       start_tap,
  output logic       stop_tap
);

  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i       (system_clk),
    .rst_ni      (reset_n),
    .scl_i       (scl_in),
    .sda_i       (sda_in),
    .sda_o       (sda_f),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  state_e     state_q,     state_d;
  logic [3:0] bitcnt_q,    bitcnt_d;
  logic [7:0] shift_q,     shift_d;
  logic [7:0] reg_addr_q,  reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q,    reg_wr_d;
  logic       reg_rd_q,    reg_rd_d;
  logic       busy_q,      busy_d;
  logic       sda_oe_q,    sda_oe_d;
  logic       rw_q,        rw_d;
  logic       rd_wait_q;
  logic       start_tap_q;
  logic       stop_tap_q;

  logic [7:0] byte_in;
  logic       last_bit;

  assign byte_in  = {shift_q[6:0], sda_f};
  assign last_bit = (bitcnt_q == 4'd1);

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= BITS_PER_BYTE;
      shift_q     <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      rd_wait_q   <= 1'b0;
      start_tap_q <= 1'b0;
      stop_tap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      rd_wait_q   <= reg_rd_q;
      start_tap_q <= start_det;
      stop_tap_q  <= stop_det;
    end
  end

  // In ACK states sda_oe_q doubles as the phase flag: the first SCL fall starts
  // the ACK, the second one (after the ACK clock) releases SDA and moves on.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;

    // Read data arrives one cycle after the strobe; present its MSB straight away.
    if (rd_wait_q && state_q == ST_RDATA) begin
      shift_d  = reg_rdata;
      sda_oe_d = ~reg_rdata[7];
    end

    case (state_q)
      ST_ADDR: begin
        if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q - 4'd1;
          if (last_bit) begin
            rw_d = sda_f;
            if (byte_in[7:1] == I2C_ADDR) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            bitcnt_d = BITS_PER_BYTE;
            if (rw_q) begin
              reg_rd_d = 1'b1;
              state_d  = ST_RDATA;
            end else begin
              state_d  = ST_PTR;
            end
          end
        end
      end
      ST_PTR: begin
        if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q - 4'd1;
          if (last_bit) begin
            reg_addr_d = byte_in;
            state_d    = ST_PTR_ACK;
          end
        end
      end
      ST_PTR_ACK, ST_WDATA_ACK: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            bitcnt_d = BITS_PER_BYTE;
            state_d  = ST_WDATA;
            if (state_q == ST_WDATA_ACK) begin
              reg_addr_d = reg_addr_q + 8'd1;
            end
          end
        end
      end
      ST_WDATA: begin
        if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q - 4'd1;
          if (last_bit) begin
            reg_wdata_d = byte_in;
            reg_wr_d    = 1'b1;
            state_d     = ST_WDATA_ACK;
          end
        end
      end
      ST_RDATA: begin
        if (scl_rise && bitcnt_q != 4'd0) begin
          bitcnt_d = bitcnt_q - 4'd1;
        end
        if (scl_fall) begin
          if (bitcnt_q == 4'd0) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RACK;
          end else begin
            shift_d  = shift_q << 1;
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      ST_RACK: begin
        // Still here at the next fall means the master answered with ACK.
        if (scl_rise && sda_f == NACK_BIT) begin
          state_d = ST_IGNORE;
          busy_d  = 1'b0;
        end else if (scl_fall) begin
          reg_addr_d = reg_addr_q + 8'd1;
          reg_rd_d   = 1'b1;
          bitcnt_d   = BITS_PER_BYTE;
          state_d    = ST_RDATA;
        end
      end
      default: begin
      end
    endcase

    if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = BITS_PER_BYTE;
      sda_oe_d = 1'b0;
      reg_wr_d = 1'b0;
      reg_rd_d = 1'b0;
    end
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      reg_wr_d = 1'b0;
      reg_rd_d = 1'b0;
    end
    if (sda_f == ACK_BIT && state_q == ST_IDLE && !start_det) begin
      busy_d = 1'b0;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;
  assign start_tap = start_tap_q;
  assign stop_tap  = stop_tap_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus master drives directed transactions while a
// scoreboard checks every register strobe against queued expectations.
module tb_i2c_target;

  logic       system_clk = 1'b0;
  logic       reset_n    = 1'b0;
  logic       scl_m      = 1'b1;
  logic       sda_m      = 1'b1;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       start_tap;
  logic       stop_tap;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target #(
    .I2C_ADDR   (7'h50),
    .FILTER_LEN (5)
  ) dut (
    .system_clk (system_clk),
    .reset_n    (reset_n),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .start_tap  (start_tap),
    .stop_tap   (stop_tap)
  );

  always #5 system_clk = ~system_clk;

  typedef struct packed {
    logic       isWrite;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        expQ[$];
  int         checks     = 0;
  int         errors     = 0;
  int         startCount = 0;
  int         stopCount  = 0;
  logic [7:0] mem [0:255];

  // Register file model with a registered read port.
  always @(posedge system_clk) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
  end

  always @(negedge system_clk) begin
    if (start_tap) startCount++;
    if (stop_tap) stopCount++;
  end

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  always @(negedge system_clk) begin
    ev_t e;
    if (reset_n && (reg_wr || reg_rd)) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL strobe: unexpected wr=%0b rd=%0b addr=%h data=%h, required no strobe",
                 reg_wr, reg_rd, reg_addr, reg_wdata);
      end else begin
        e = expQ.pop_front();
        if (e.isWrite !== reg_wr || e.isWrite === reg_rd || e.addr !== reg_addr ||
            (e.isWrite && e.data !== reg_wdata)) begin
          errors++;
          $display("[TB] FAIL strobe: got wr=%0b rd=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                   reg_wr, reg_rd, reg_addr, reg_wdata, e.isWrite, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
    scl_m = scl;
    sda_m = sda;
    repeat (cycles) @(posedge system_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic pushWr(input logic [7:0] a, input logic [7:0] d);
    expQ.push_back('{isWrite: 1'b1, addr: a, data: d});
  endtask

  task automatic pushRd(input logic [7:0] a);
    expQ.push_back('{isWrite: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic writeBit(input logic b);
    applyStimulus(1'b0, b, 10);
    applyStimulus(1'b1, b, 20);
    applyStimulus(1'b0, b, 10);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 10);
    b = sda_in;
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 10);
  endtask

  task automatic busStart();
    if (scl_m == 1'b0) applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  task automatic busStop();
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 20);
  endtask

  task automatic sendChecked(input logic [7:0] b, input logic expAck, input string name);
    logic ack;
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    readBit(ack);
    checkOutput(name, 32'(ack), 32'(expAck));
  endtask

  task automatic readChecked(input logic nack, input logic [7:0] expByte, input string name);
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) readBit(b[i]);
    writeBit(nack);
    checkOutput(name, 32'(b), 32'(expByte));
  endtask

  initial begin
    int startsBefore;
    int stopsBefore;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    mem[8'h40] = 8'h00;

    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("reset reg_addr", 32'(reg_addr), 32'h00);
    checkOutput("reset reg_wdata", 32'(reg_wdata), 32'h00);
    checkOutput("reset strobes", 32'({reg_wr, reg_rd, start_tap, stop_tap}), 32'd0);

    $display("[TB] test 1: write two bytes from pointer 0x10");
    pushWr(8'h10, 8'hA5);
    pushWr(8'h11, 8'h3C);
    busStart();
    sendChecked(8'hA0, 1'b0, "t1 addr ack");
    checkOutput("t1 busy after match", 32'(busy), 32'd1);
    sendChecked(8'h10, 1'b0, "t1 ptr ack");
    sendChecked(8'hA5, 1'b0, "t1 data0 ack");
    sendChecked(8'h3C, 1'b0, "t1 data1 ack");
    busStop();
    checkOutput("t1 busy after stop", 32'(busy), 32'd0);
    checkOutput("t1 start taps", 32'(startCount), 32'd1);
    checkOutput("t1 stop taps", 32'(stopCount), 32'd1);

    $display("[TB] test 2: pointer write, repeated START, two-byte read");
    pushRd(8'h20);
    pushRd(8'h21);
    busStart();
    sendChecked(8'hA0, 1'b0, "t2 addr w ack");
    sendChecked(8'h20, 1'b0, "t2 ptr ack");
    busStart();
    sendChecked(8'hA1, 1'b0, "t2 addr r ack");
    readChecked(1'b0, 8'h11, "t2 read byte0");
    readChecked(1'b1, 8'h22, "t2 read byte1");
    checkOutput("t2 busy after nack", 32'(busy), 32'd0);
    busStop();

    $display("[TB] test 3: foreign address is ignored");
    busStart();
    sendChecked(8'hA2, 1'b1, "t3 addr nack");
    checkOutput("t3 busy", 32'(busy), 32'd0);
    sendChecked(8'h5A, 1'b1, "t3 data nack");
    busStop();

    $display("[TB] test 4: pointer wraps from 0xFF");
    pushWr(8'hFF, 8'h01);
    pushWr(8'h00, 8'h02);
    busStart();
    sendChecked(8'hA0, 1'b0, "t4 addr ack");
    sendChecked(8'hFF, 1'b0, "t4 ptr ack");
    sendChecked(8'h01, 1'b0, "t4 data0 ack");
    sendChecked(8'h02, 1'b0, "t4 data1 ack");
    busStop();
    checkOutput("t4 pointer wrapped", 32'(reg_addr), 32'h01);

    $display("[TB] test 5: STOP mid-byte and SDA glitch");
    busStart();
    sendChecked(8'hA0, 1'b0, "t5 addr ack");
    sendChecked(8'h30, 1'b0, "t5 ptr ack");
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b1);
    writeBit(1'b0);
    busStop();
    checkOutput("t5 wdata kept", 32'(reg_wdata), 32'h02);
    checkOutput("t5 pointer", 32'(reg_addr), 32'h30);
    startsBefore = startCount;
    stopsBefore  = stopCount;
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 30);
    checkOutput("t5 no false start", 32'(startCount), 32'(startsBefore));
    checkOutput("t5 no false stop", 32'(stopCount), 32'(stopsBefore));
    checkOutput("t5 busy", 32'(busy), 32'd0);

    $display("[TB] test 6: asynchronous reset while driving read data");
    pushRd(8'h40);
    busStart();
    sendChecked(8'hA0, 1'b0, "t6 addr w ack");
    sendChecked(8'h40, 1'b0, "t6 ptr ack");
    busStart();
    sendChecked(8'hA1, 1'b0, "t6 addr r ack");
    for (int i = 0; i < 40 && !sda_oe; i++) applyStimulus(1'b0, 1'b1, 1);
    checkOutput("t6 sda driven", 32'(sda_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6 sda released", 32'(sda_oe), 32'd0);
    checkOutput("t6 busy cleared", 32'(busy), 32'd0);
    checkOutput("t6 pointer cleared", 32'(reg_addr), 32'h00);
    applyStimulus(1'b0, 1'b1, 3);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 10);
    pushWr(8'h05, 8'h77);
    busStart();
    sendChecked(8'hA0, 1'b0, "t6 post-reset addr ack");
    sendChecked(8'h05, 1'b0, "t6 post-reset ptr ack");
    sendChecked(8'h77, 1'b0, "t6 post-reset data ack");
    busStop();
    applyStimulus(1'b1, 1'b1, 20);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
